// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 mouse packet controller: FSM encoding,
// byte-0 bit positions and axis saturation limits.
package ps2_pkg;

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2
    } ps2_state_e;

    localparam int LEFT   = 0;
    localparam int RIGHT  = 1;
    localparam int MIDDLE = 2;
    localparam int SYNC   = 3;
    localparam int XSIGN  = 4;
    localparam int YSIGN  = 5;
    localparam int XOVF   = 6;
    localparam int YOVF   = 7;

    localparam int PACKET_BYTES = 3;

    localparam logic [8:0] AXIS_MAX = 9'h0FF;
    localparam logic [8:0] AXIS_MIN = 9'h100;

endpackage

// File: rtl/ps2_axis_decode.sv
// Combinational decode of one PS/2 movement axis: sign-extends the 8-bit
// magnitude byte to 9 bits and saturates when the overflow flag is set.
module ps2_axis_decode
    import ps2_pkg::*;
(
    input  logic       sign_i,
    input  logic       ovf_i,
    input  logic [7:0] data_i,
    output logic [8:0] axis_o
);

    logic signed [8:0] axis_s;

    // An overflowed axis reports the extreme value in the direction of motion.
    function automatic logic signed [8:0] sat_axis(input logic sign, input logic ovf,
                                                   input logic [7:0] data);
        logic signed [8:0] result;
        if (ovf) begin
            result = sign ? $signed(AXIS_MIN) : $signed(AXIS_MAX);
        end else begin
            result = $signed({sign, data});
        end
        return result;
    endfunction

    always_comb begin
        axis_s = sat_axis(sign_i, ovf_i, data_i);
    end

    assign axis_o = axis_s;

endmodule

// File: rtl/ps2_packet_controller.sv
// Assembles 3-byte PS/2 mouse packets, decodes X/Y movement and issues
// package_done / reset_registers / frame_error strobes for the Z accumulator.
module ps2_packet_controller
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_error,
    output logic [8:0] x_axis,
    output logic [8:0] y_axis,
    output logic [2:0] buttons,
    output logic       package_done,
    output logic       reset_registers,
    output logic       frame_error,
    output logic       busy
);

    ps2_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       b0_q, b0_d;
    logic [7:0]       xb_q, xb_d;
    logic [8:0]       x_q, x_d;
    logic [8:0]       y_q, y_d;
    logic [2:0]       btn_q, btn_d;
    logic             pd_q, pd_d;
    logic             rr_q, rr_d;
    logic             fe_q, fe_d;
    logic             prev_mid_q, prev_mid_d;

    logic [8:0]       x_dec, y_dec;

    // The Y byte is decoded straight from rx_data so the packet completes on its strobe.
    ps2_axis_decode u_x_decode (
        .sign_i (b0_q[XSIGN]),
        .ovf_i  (b0_q[XOVF]),
        .data_i (xb_q),
        .axis_o (x_dec)
    );

    ps2_axis_decode u_y_decode (
        .sign_i (b0_q[YSIGN]),
        .ovf_i  (b0_q[YOVF]),
        .data_i (rx_data),
        .axis_o (y_dec)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        b0_d       = b0_q;
        xb_d       = xb_q;
        x_d        = x_q;
        y_d        = y_q;
        btn_d      = btn_q;
        pd_d       = 1'b0;
        rr_d       = 1'b0;
        fe_d       = 1'b0;
        prev_mid_d = prev_mid_q;

        if (rx_error) begin
            state_d = WAIT_B0;
            cnt_d   = '0;
            fe_d    = 1'b1;
        end else if (rx_valid) begin
            cnt_d = '0;
            case (state_q)
                WAIT_B0: begin
                    if (rx_data[SYNC]) begin
                        b0_d    = rx_data;
                        state_d = WAIT_B1;
                    end else begin
                        fe_d = 1'b1;
                    end
                end
                WAIT_B1: begin
                    xb_d    = rx_data;
                    state_d = WAIT_B2;
                end
                WAIT_B2: begin
                    state_d    = WAIT_B0;
                    x_d        = x_dec;
                    y_d        = y_dec;
                    btn_d      = b0_q[MIDDLE:LEFT];
                    pd_d       = 1'b1;
                    rr_d       = b0_q[MIDDLE] & ~prev_mid_q;
                    prev_mid_d = b0_q[MIDDLE];
                end
                default: state_d = WAIT_B0;
            endcase
        end else if (state_q != WAIT_B0) begin
            // Expires on the TIMEOUT_CYCLES-th idle cycle after the last accepted byte.
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = WAIT_B0;
                cnt_d   = '0;
                fe_d    = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WAIT_B0;
            cnt_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            btn_q      <= '0;
            pd_q       <= 1'b0;
            rr_q       <= 1'b0;
            fe_q       <= 1'b0;
            prev_mid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            btn_q      <= btn_d;
            pd_q       <= pd_d;
            rr_q       <= rr_d;
            fe_q       <= fe_d;
            prev_mid_q <= prev_mid_d;
        end
    end

    always_ff @(posedge clk) begin
        b0_q <= b0_d;
        xb_q <= xb_d;
    end

    assign x_axis          = x_q;
    assign y_axis          = y_q;
    assign buttons         = btn_q;
    assign package_done    = pd_q;
    assign reset_registers = rr_q;
    assign frame_error     = fe_q;
    assign busy            = (state_q != WAIT_B0);

endmodule

// File: tb/tb_ps2_packet_controller.sv
// Directed bench for ps2_packet_controller with a short timeout; inputs change
// on the falling edge and registered outputs are sampled on the following falling edge.
module tb_ps2_packet_controller;

    logic       clk;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_error;
    logic [8:0] x_axis;
    logic [8:0] y_axis;
    logic [2:0] buttons;
    logic       package_done;
    logic       reset_registers;
    logic       frame_error;
    logic       busy;

    int total;
    int passed;

    ps2_packet_controller #(
        .TIMEOUT_CYCLES (16),
        .CNT_W          (5)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_valid        (rx_valid),
        .rx_data         (rx_data),
        .rx_error        (rx_error),
        .x_axis          (x_axis),
        .y_axis          (y_axis),
        .buttons         (buttons),
        .package_done    (package_done),
        .reset_registers (reset_registers),
        .frame_error     (frame_error),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock: apply inputs, let the rising edge take them, return at the next falling edge.
    task automatic step(input logic v, input logic e, input logic [7:0] d);
        rx_valid = v;
        rx_error = e;
        rx_data  = d;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_error = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        step(1'b1, 1'b0, a);
        step(1'b1, 1'b0, b);
        step(1'b1, 1'b0, c);
    endtask

    initial begin
        total    = 0;
        passed   = 0;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_error = 1'b0;
        rx_data  = 8'h00;
        @(negedge clk);
        idle(2);
        rst = 1'b0;

        chk("rst_x", x_axis, 9'h000);
        chk("rst_y", y_axis, 9'h000);
        chk("rst_btn", {6'd0, buttons}, 9'h000);
        chk("rst_pd", {8'd0, package_done}, 9'h000);
        chk("rst_rr", {8'd0, reset_registers}, 9'h000);
        chk("rst_fe", {8'd0, frame_error}, 9'h000);
        chk("rst_busy", {8'd0, busy}, 9'h000);

        // Basic packet
        step(1'b1, 1'b0, 8'h08);
        chk("basic_busy_b1", {8'd0, busy}, 9'h001);
        step(1'b1, 1'b0, 8'h05);
        step(1'b1, 1'b0, 8'hFD);
        chk("basic_pd", {8'd0, package_done}, 9'h001);
        chk("basic_x", x_axis, 9'h005);
        chk("basic_y", y_axis, 9'h0FD);
        chk("basic_btn", {6'd0, buttons}, 9'h000);
        chk("basic_rr", {8'd0, reset_registers}, 9'h000);
        chk("basic_fe", {8'd0, frame_error}, 9'h000);
        chk("basic_busy", {8'd0, busy}, 9'h000);
        idle(1);
        chk("basic_pd_drop", {8'd0, package_done}, 9'h000);
        chk("basic_x_hold", x_axis, 9'h005);

        // Sign and saturation
        pkt(8'h18, 8'hFB, 8'h00);
        chk("neg_x", x_axis, 9'h1FB);
        chk("neg_y", y_axis, 9'h000);
        pkt(8'h48, 8'h12, 8'h00);
        chk("ovf_pos_x", x_axis, 9'h0FF);
        pkt(8'h58, 8'h12, 8'h00);
        chk("ovf_neg_x", x_axis, 9'h100);
        pkt(8'h88, 8'h00, 8'h34);
        chk("ovf_pos_y", y_axis, 9'h0FF);
        chk("ovf_pos_y_x", x_axis, 9'h000);
        pkt(8'hA8, 8'h00, 8'h34);
        chk("ovf_neg_y", y_axis, 9'h100);

        // Middle-button edge detection
        pkt(8'h0C, 8'h00, 8'h00);
        chk("mid1_pd", {8'd0, package_done}, 9'h001);
        chk("mid1_rr", {8'd0, reset_registers}, 9'h001);
        chk("mid1_btn", {6'd0, buttons}, 9'h004);
        idle(1);
        chk("mid1_rr_drop", {8'd0, reset_registers}, 9'h000);
        pkt(8'h0C, 8'h00, 8'h00);
        chk("mid2_pd", {8'd0, package_done}, 9'h001);
        chk("mid2_rr", {8'd0, reset_registers}, 9'h000);
        pkt(8'h08, 8'h00, 8'h00);
        chk("mid_rel_rr", {8'd0, reset_registers}, 9'h000);
        pkt(8'h0C, 8'h00, 8'h00);
        chk("mid3_rr", {8'd0, reset_registers}, 9'h001);

        // Resync on a byte without the sync bit
        step(1'b1, 1'b0, 8'h05);
        chk("resync_fe", {8'd0, frame_error}, 9'h001);
        chk("resync_busy", {8'd0, busy}, 9'h000);
        chk("resync_pd", {8'd0, package_done}, 9'h000);
        pkt(8'h08, 8'h01, 8'h02);
        chk("resync_pd2", {8'd0, package_done}, 9'h001);
        chk("resync_fe2", {8'd0, frame_error}, 9'h000);
        chk("resync_x", x_axis, 9'h001);
        chk("resync_y", y_axis, 9'h002);

        // Timeout after 16 idle cycles
        step(1'b1, 1'b0, 8'h08);
        idle(15);
        chk("to_busy_pre", {8'd0, busy}, 9'h001);
        chk("to_fe_pre", {8'd0, frame_error}, 9'h000);
        idle(1);
        chk("to_fe", {8'd0, frame_error}, 9'h001);
        chk("to_busy", {8'd0, busy}, 9'h000);
        chk("to_x_hold", x_axis, 9'h001);
        pkt(8'h08, 8'h07, 8'h09);
        chk("to_next_pd", {8'd0, package_done}, 9'h001);
        chk("to_next_x", x_axis, 9'h007);
        chk("to_next_y", y_axis, 9'h009);

        // Byte arriving on the expiry cycle is accepted
        step(1'b1, 1'b0, 8'h08);
        idle(15);
        step(1'b1, 1'b0, 8'h03);
        chk("exp_fe", {8'd0, frame_error}, 9'h000);
        chk("exp_busy", {8'd0, busy}, 9'h001);
        step(1'b1, 1'b0, 8'h04);
        chk("exp_pd", {8'd0, package_done}, 9'h001);
        chk("exp_x", x_axis, 9'h003);
        chk("exp_y", y_axis, 9'h004);

        // Receiver error mid-packet
        step(1'b1, 1'b0, 8'h08);
        step(1'b0, 1'b1, 8'h00);
        chk("err_fe", {8'd0, frame_error}, 9'h001);
        chk("err_pd", {8'd0, package_done}, 9'h000);
        chk("err_busy", {8'd0, busy}, 9'h000);
        chk("err_x_hold", x_axis, 9'h003);

        // Error with a simultaneous byte drops the byte
        step(1'b1, 1'b0, 8'h08);
        step(1'b1, 1'b1, 8'h05);
        chk("errv_fe", {8'd0, frame_error}, 9'h001);
        chk("errv_busy", {8'd0, busy}, 9'h000);
        pkt(8'h08, 8'h0A, 8'h0B);
        chk("errv_x", x_axis, 9'h00A);
        chk("errv_y", y_axis, 9'h00B);

        // Error while idle still flags
        idle(1);
        step(1'b0, 1'b1, 8'h00);
        chk("err_idle_fe", {8'd0, frame_error}, 9'h001);

        // Reset mid-packet
        step(1'b1, 1'b0, 8'h08);
        step(1'b1, 1'b0, 8'h05);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("rstmid_busy", {8'd0, busy}, 9'h000);
        chk("rstmid_fe", {8'd0, frame_error}, 9'h000);
        chk("rstmid_pd", {8'd0, package_done}, 9'h000);
        chk("rstmid_x", x_axis, 9'h000);
        pkt(8'h08, 8'h01, 8'h01);
        chk("rstmid_pd2", {8'd0, package_done}, 9'h001);
        chk("rstmid_x2", x_axis, 9'h001);
        chk("rstmid_y2", y_axis, 9'h001);

        idle(2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ps2_packet_controller.md
Name: ps2_packet_controller

Overview:
Sequences the Z-axis accumulation datapath from the PS/2 byte stream. Assembles 3-byte standard mouse packets from the PS/2 receiver and decodes signed 9-bit X/Y movement with saturation on overflow. Issues one package_done strobe per valid packet and a reset_registers strobe on a middle-button press, both of which the accumulator register consumes. Resynchronises on framing errors, receiver errors and inter-byte timeouts.

Parameters:
TIMEOUT_CYCLES, 100000, maximum clk cycles allowed between accepted bytes of one packet (2 ms at 50 MHz)
CNT_W, 17, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
rx_valid  in  1  one-cycle strobe, rx_data holds a received byte
rx_data  in  8  received PS/2 byte
rx_error  in  1  one-cycle strobe, receiver parity/stop-bit error
x_axis  out  9  signed X movement of last packet, two's complement
y_axis  out  9  signed Y movement of last packet, two's complement
buttons  out  3  {middle, right, left} of last packet
package_done  out  1  one-cycle strobe, x_axis/y_axis valid
reset_registers  out  1  one-cycle strobe, middle button newly pressed
frame_error  out  1  one-cycle strobe, packet discarded
busy  out  1  high while a packet is partially received

Behaviour:
- Reset (rst=1 at a clock edge): state WAIT_B0; x_axis=0, y_axis=0, buttons=0, package_done=0, reset_registers=0, frame_error=0, busy=0; timeout counter=0; stored previous-middle bit=0. Reset mid-packet discards the partial packet without a frame_error.
- States: WAIT_B0, WAIT_B1, WAIT_B2. busy=1 in WAIT_B1 and WAIT_B2.
- WAIT_B0 + rx_valid: if rx_data[3]=1, latch byte0 and go to WAIT_B1. Otherwise discard, pulse frame_error, stay.
- WAIT_B1 + rx_valid: latch X byte, go to WAIT_B2.
- WAIT_B2 + rx_valid: go to WAIT_B0. At the same edge, register the outputs:
  - x_axis = {b0[4], xbyte}, y_axis = {b0[5], ybyte}
  - if b0[6] (X overflow): x_axis = b0[4] ? 9'h100 : 9'h0FF. Y uses b0[7] with the same rule.
  - buttons = b0[2:0]
  - package_done=1 for exactly that one following cycle (latency: 1 cycle after the byte-2 strobe).
- reset_registers=1 in the same cycle as package_done iff b0[2]=1 and the stored previous middle=0. The stored previous middle updates only on completed packets.
- x_axis/y_axis/buttons hold their values until the next completed packet. They are not altered by errors.
- Timeout: the counter clears on every accepted byte and increments each cycle in WAIT_B1/WAIT_B2. On reaching TIMEOUT_CYCLES: go to WAIT_B0, pulse frame_error, clear the counter. The counter is held at 0 in WAIT_B0.
- rx_error in any state: go to WAIT_B0, pulse frame_error (also in WAIT_B0). The partial packet is discarded and no package_done is issued.
- Simultaneous events:
  - rx_error and rx_valid: rx_error wins, the byte is dropped.
  - rx_valid in the cycle the timeout expires: rx_valid wins and the byte is accepted.
- Strobe rules:
  - package_done and frame_error are never high in the same cycle.
  - All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package ps2_pkg holds:
  - state encoding (WAIT_B0=0, WAIT_B1=1, WAIT_B2=2)
  - byte-0 bit indices: LEFT=0, RIGHT=1, MIDDLE=2, SYNC=3, XSIGN=4, YSIGN=5, XOVF=6, YOVF=7
  - PACKET_BYTES=3
  - saturation constants AXIS_MAX=9'h0FF, AXIS_MIN=9'h100
- One natural sub-module, ps2_axis_decode: combinational sign-extend plus overflow saturation. Instanced twice, once for X and once for Y.

Test Plan:
- Basic packet: bytes 08,05,FD -> one cycle after byte 3: package_done=1, x_axis=9'h005, y_axis=9'h0FD, buttons=3'b000, reset_registers=0.
- Negative X and overflow:
  - bytes 18,FB,00 -> x_axis=9'h1FB.
  - bytes 48,12,00 -> x_axis=9'h0FF.
  - bytes 58,12,00 -> x_axis=9'h100.
- Middle button edge: two packets each 0C,00,00 -> reset_registers=1 with the first package_done only. Then packet 08,00,00 followed by 0C,00,00 -> the pulse fires again.
- Resync: stream 05,08,01,02 -> frame_error pulse on 05, then package_done with x_axis=9'h001, y_axis=9'h002.
- Timeout (TIMEOUT_CYCLES=16):
  - byte 08, then 16 idle cycles -> frame_error, busy=0. The next byte 08 is treated as byte0.
  - rx_valid arriving exactly on expiry -> accepted, no frame_error.
- Error and reset mid-packet:
  - 08,rx_error -> frame_error, no package_done.
  - 08,05 then rst -> busy=0, no strobes. Then 08,01,01 completes normally.
